// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver with prefix decoder and key-event FIFO
// Optional typematic-repeat suppression is enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_data_i,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] clk_sh_q, clk_sh_d;
  logic [FILTER_LEN-1:0] data_sh_q, data_sh_d;
  logic                  clk_filt_q, clk_filt_d;
  logic                  data_filt_q, data_filt_d;
  logic                  clk_prev_q, clk_prev_d;
  logic                  fall;

  state_t                state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  par_ok_q, par_ok_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  err_d;
  logic                  frame_err_q;
  logic                  byte_done_q, byte_done_d;
  logic [7:0]            byte_q, byte_d;

  logic                  ext_q, ext_d;
  logic                  brk_q, brk_d;
  logic                  push, push_en;
  logic [9:0]            push_data;

  logic [9:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  full, pop, wr_en;
  logic [9:0]            head;

  // Input conditioning: 2-FF synchroniser feeding an all-ones/all-zeros glitch filter.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_sh_d    = {clk_sh_q[FILTER_LEN-2:0], clk_sync_q[1]};
    data_sh_d   = {data_sh_q[FILTER_LEN-2:0], data_sync_q[1]};
    clk_filt_d  = clk_filt_q;
    data_filt_d = data_filt_q;
    if (&clk_sh_q)        clk_filt_d = 1'b1;
    else if (~|clk_sh_q)  clk_filt_d = 1'b0;
    if (&data_sh_q)       data_filt_d = 1'b1;
    else if (~|data_sh_q) data_filt_d = 1'b0;
    clk_prev_d  = clk_filt_q;
  end

  assign fall = clk_prev_q & ~clk_filt_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    err_d       = 1'b0;
    byte_done_d = 1'b0;
    byte_d      = byte_q;

    if (state_q == IDLE || fall) tmo_d = '0;
    else                         tmo_d = tmo_q + TW'(1);

    // Timeout wins over a coincident fall: the frame is abandoned either way.
    if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!data_filt_q) begin
            state_d   = DATA;
            bit_cnt_d = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {data_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shift_q, data_filt_q};
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (data_filt_q && par_ok_q) begin
            byte_done_d = 1'b1;
            byte_d      = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    push      = 1'b0;
    push_data = {ext_q, brk_q, byte_q};
    if (byte_done_q) begin
      if (byte_q == 8'hE0)      ext_d = 1'b1;
      else if (byte_q == 8'hF0) brk_d = 1'b1;
      else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_v_q, held_v_d;
  logic       held_ext_q, held_ext_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_match;

  assign held_match = held_v_q && (held_ext_q == ext_q) && (held_code_q == byte_q);

  // Auto-repeat makes of the currently held key are swallowed before the FIFO.
  always_comb begin
    held_v_d    = held_v_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    push_en     = push;
    if (push && !brk_q) begin
      if (held_match) begin
        push_en = 1'b0;
      end else begin
        held_v_d    = 1'b1;
        held_ext_d  = ext_q;
        held_code_d = byte_q;
      end
    end else if (push && brk_q && held_match) begin
      held_v_d = 1'b0;
    end
    if (err_d) held_v_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_v_q    <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
    end else begin
      held_v_q    <= held_v_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
    end
  end
`else
  assign push_en = push;
`endif

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign pop  = evt_valid & evt_ready;

  always_comb begin
    wr_en      = push_en & (~full | pop);
    overflow_d = push_en & full & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_sh_q    <= '1;
      data_sh_q   <= '1;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_ok_q    <= 1'b0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      byte_done_q <= 1'b0;
      byte_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_sh_q    <= clk_sh_d;
      data_sh_q   <= data_sh_d;
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      tmo_q       <= tmo_d;
      frame_err_q <= err_d;
      byte_done_q <= byte_done_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Head fields are forced to zero while empty so outputs are clean out of reset.
  assign head       = mem_q[rd_ptr_q];
  assign evt_valid  = (count_q != '0);
  assign evt_code   = evt_valid ? head[7:0] : 8'h00;
  assign evt_break  = evt_valid & head[8];
  assign evt_ext    = evt_valid & head[9];
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - directed self-checking bench for ps2_rx_fifo
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int TMO   = 4500;
  localparam int HALF  = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk_i = 1'b1;
  logic       ps2_data_i = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int ovf_pulses = 0;
  logic [9:0] evq [$];
  logic [7:0] burst [10];

  ps2_rx_fifo #(.FILTER_LEN(8), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .fifo_count(fifo_count),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_pulses++;
    if (overflow) ovf_pulses++;
    if (evt_valid && evt_ready) evq.push_back({evt_ext, evt_break, evt_code});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives nbits of an 11-bit frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int half, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data_i = f[i];
      tick(half);
      ps2_clk_i = 1'b0;
      tick(half);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
    tick(2 * half);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, HALF, 11);
  endtask

  initial begin
    burst = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D};
    tick(3);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_count", fifo_count, 4'd0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_code", evt_code, 8'h00);
    rst_n = 1'b1;
    tick(5);

    // 1: slow valid frame 0x1C, held in the FIFO
    send_frame(8'h1C, 1'b0, 1'b0, 2000, 11);
    check("t1_valid", evt_valid, 1'b1);
    check("t1_code", evt_code, 8'h1C);
    check("t1_ext", evt_ext, 1'b0);
    check("t1_brk", evt_break, 1'b0);
    check("t1_count", fifo_count, 4'd1);
    check("t1_noerr", err_pulses, 0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    tick(1);
    check("t1_popped", fifo_count, 4'd0);
    check("t1_popval", evq[0], 10'h01C);
    evq.delete();

    // 2: break and extended-break prefixes
    evt_ready = 1'b1;
    send(8'hF0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_n", evq.size(), 2);
    check("t2_ev0", evq[0], {2'b01, 8'h1C});
    check("t2_ev1", evq[1], {2'b11, 8'h75});
    evq.delete();

    // 3: bad parity then bad stop
    send_frame(8'h1C, 1'b1, 1'b0, HALF, 11);
    send_frame(8'h1C, 1'b0, 1'b1, HALF, 11);
    check("t3_err", err_pulses, 2);
    check("t3_count", fifo_count, 4'd0);
    check("t3_noev", evq.size(), 0);

    // 4: truncated frame times out, then recovery
    send_frame(8'h05, 1'b0, 1'b0, HALF, 4);
    tick(TMO + 200);
    check("t4_err", err_pulses, 3);
    send(8'h23);
    check("t4_n", evq.size(), 1);
    check("t4_ev", evq[0], {2'b00, 8'h23});
    check("t4_err2", err_pulses, 3);
    evq.delete();

    // 5: overflow with consumer stalled, then drain
    evt_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) send(burst[i]);
    check("t5_count", fifo_count, 4'd8);
    check("t5_ovf", ovf_pulses, 2);
    check("t5_head", evt_code, 8'h15);
    evt_ready = 1'b1;
    tick(20);
    check("t5_n", evq.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++) check($sformatf("t5_ev%0d", i), evq[i], {2'b00, burst[i]});
    check("t5_valid", evt_valid, 1'b0);
    check("t5_count0", fifo_count, 4'd0);
    evq.delete();

    // 6: typematic repeats
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    check("t6_n", evq.size(), 3);
    check("t6_ev0", evq[0], {2'b00, 8'h1C});
    check("t6_ev1", evq[1], {2'b01, 8'h1C});
    check("t6_ev2", evq[2], {2'b00, 8'h1C});
`else
    check("t6_n", evq.size(), 5);
    check("t6_ev0", evq[0], {2'b00, 8'h1C});
    check("t6_ev1", evq[1], {2'b00, 8'h1C});
    check("t6_ev2", evq[2], {2'b00, 8'h1C});
    check("t6_ev3", evq[3], {2'b01, 8'h1C});
    check("t6_ev4", evq[4], {2'b00, 8'h1C});
`endif
    evq.delete();

    // 7: reset mid-frame with FIFO contents
    evt_ready = 1'b0;
    send(8'h1B);
    check("t7_count", fifo_count, 4'd1);
    send_frame(8'h33, 1'b0, 1'b0, HALF, 3);
    rst_n = 1'b0;
    #1;
    check("t7_rvalid", evt_valid, 1'b0);
    check("t7_rcount", fifo_count, 4'd0);
    tick(3);
    rst_n = 1'b1;
    tick(5);
    evt_ready = 1'b1;
    send(8'h29);
    check("t7_n", evq.size(), 1);
    check("t7_ev", evq[0], {2'b00, 8'h29});
    check("t7_err", err_pulses, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
